bht_update_scheduler: RTL and testbench

//  Owns the branch history table (BHT) of 2-bit predictor states and schedules its single table port.
//  IF-stage lookups always win the port. EX-stage resolved-branch updates wait in a FIFO.

---
 rtl/bht_update_scheduler.sv | 139 +++++++++++++
 tb/tb_bht_update_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_scheduler.sv
// Branch history table of 2-bit predictors with a single table port.
// IF lookups own the port; queued EX updates are applied read-modify-write when it is idle.
module bht_update_scheduler #(
  parameter int IDX_W  = 6,
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lookup_valid,
  input  logic [IDX_W-1:0]           lookup_idx,
  output logic                       pred_valid,
  output logic [1:0]                 pred_state,
  output logic                       pred_taken,
  input  logic                       upd_valid,
  input  logic [IDX_W-1:0]           upd_idx,
  input  logic                       upd_mispred,
  output logic                       upd_ready,
  input  logic                       init_req,
  output logic                       busy,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int PTR_W   = $clog2(QDEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {RUN, SWEEP} state_e;

  state_e             state_q, state_d;
  logic [1:0]         table_q [ENTRIES];
  logic [1:0]         table_d [ENTRIES];
  logic [IDX_W-1:0]   fifo_idx_q [QDEPTH];
  logic [IDX_W-1:0]   fifo_idx_d [QDEPTH];
  logic               fifo_mp_q [QDEPTH];
  logic               fifo_mp_d [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic               pred_valid_q, pred_valid_d;
  logic [1:0]         pred_state_q, pred_state_d;
  logic               push, pop;

  function automatic logic [1:0] bht_next(input logic [1:0] s, input logic mp);
    if (!mp) return {s[1], 1'b0};
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  assign upd_ready  = (count_q < CNT_W'(QDEPTH)) & (state_q == RUN) & ~init_req;
  assign busy       = (state_q == SWEEP);
  assign q_count    = count_q;
  assign pred_valid = pred_valid_q;
  assign pred_state = pred_state_q;
  assign pred_taken = pred_state_q[1];

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    fifo_idx_d   = fifo_idx_q;
    fifo_mp_d    = fifo_mp_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    sweep_idx_d  = sweep_idx_q;
    pred_valid_d = lookup_valid;
    pred_state_d = pred_state_q;
    push         = upd_valid & upd_ready;
    pop          = 1'b0;

    // Lookup reads the table as it stands before this cycle's write.
    if (lookup_valid)
      pred_state_d = (state_q == SWEEP) ? 2'b01 : table_q[lookup_idx];

    case (state_q)
      RUN: begin
        if (init_req) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
        end else begin
          if (!lookup_valid && count_q != '0) begin
            pop = 1'b1;
            table_d[fifo_idx_q[rd_ptr_q]] =
              bht_next(table_q[fifo_idx_q[rd_ptr_q]], fifo_mp_q[rd_ptr_q]);
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
          if (push) begin
            fifo_idx_d[wr_ptr_q] = upd_idx;
            fifo_mp_d[wr_ptr_q]  = upd_mispred;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
      end
      SWEEP: begin
        table_d[sweep_idx_q] = 2'b01;
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == {IDX_W{1'b1}})
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_idx_q[i] <= '0;
        fifo_mp_q[i]  <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sweep_idx_q  <= '0;
      pred_valid_q <= 1'b0;
      pred_state_q <= 2'b01;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      fifo_idx_q   <= fifo_idx_d;
      fifo_mp_q    <= fifo_mp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sweep_idx_q  <= sweep_idx_d;
      pred_valid_q <= pred_valid_d;
      pred_state_q <= pred_state_d;
    end
  end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Scoreboarded bench for bht_update_scheduler: a queue-based reference model predicts
// every lookup response and per-cycle FIFO/sweep status.
module tb_bht_update_scheduler;
  localparam int IDX_W   = 6;
  localparam int QDEPTH  = 4;
  localparam int ENTRIES = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lookup_valid = 1'b0;
  logic [IDX_W-1:0] lookup_idx = '0;
  logic             pred_valid;
  logic [1:0]       pred_state;
  logic             pred_taken;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_mispred = 1'b0;
  logic             upd_ready;
  logic             init_req = 1'b0;
  logic             busy;
  logic [2:0]       q_count;

  bht_update_scheduler #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .pred_valid(pred_valid), .pred_state(pred_state), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_mispred(upd_mispred),
    .upd_ready(upd_ready), .init_req(init_req), .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int mp; } upd_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_tbl [ENTRIES];
  upd_t m_fifo [$];
  bit   m_busy;
  int   m_sweep;
  int   exp_q [$];

  function automatic int next_state(input int s, input int mp);
    if (mp == 0) return (s >= 2) ? 2 : 0;
    case (s)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 1;
    m_fifo.delete();
    m_busy  = 1'b0;
    m_sweep = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive at negedge, check status, advance the model.
  task automatic applyStimulus(input bit lv, input int li, input bit uv, input int ui,
                               input bit um, input bit ir);
    bit   rdy;
    upd_t e;
    @(negedge clk);
    lookup_valid = lv;
    lookup_idx   = IDX_W'(li);
    upd_valid    = uv;
    upd_idx      = IDX_W'(ui);
    upd_mispred  = um;
    init_req     = ir;
    #1;
    rdy = (m_fifo.size() < QDEPTH) && !m_busy && !ir;
    checkOutput("upd_ready", upd_ready, rdy);
    checkOutput("q_count", q_count, m_fifo.size());
    checkOutput("busy", busy, m_busy);
    if (lv) exp_q.push_back(m_busy ? 1 : m_tbl[li]);
    if (!m_busy) begin
      if (ir) begin
        m_fifo.delete();
        m_busy  = 1'b1;
        m_sweep = 0;
      end else begin
        if (!lv && m_fifo.size() > 0) begin
          e = m_fifo.pop_front();
          m_tbl[e.idx] = next_state(m_tbl[e.idx], e.mp);
        end
        if (uv && rdy) begin
          e.idx = ui;
          e.mp  = um;
          m_fifo.push_back(e);
        end
      end
    end else begin
      m_tbl[m_sweep] = 1;
      m_sweep++;
      if (m_sweep == ENTRIES) m_busy = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(1, i, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_q_count", q_count, 0);
    checkOutput("rst_pred_valid", pred_valid, 0);
    checkOutput("rst_pred_state", pred_state, 1);
    model_reset();
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    init_req     = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (rst_n) begin
      if (pred_valid) begin
        if (exp_q.size() == 0) checkOutput("pred_valid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("pred_state", pred_state, e);
          checkOutput("pred_taken", pred_taken, e >> 1);
        end
      end else if (exp_q.size() > 0) begin
        checkOutput("pred_valid_missing", 0, 1);
        exp_q.delete();
      end
    end
  end

  initial begin
    int n;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("reset_pred_valid", pred_valid, 0);
    checkOutput("reset_pred_state", pred_state, 1);
    checkOutput("reset_pred_taken", pred_taken, 0);
    checkOutput("reset_upd_ready", upd_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_q_count", q_count, 0);

    applyStimulus(1, 5, 0, 0, 0, 0);
    idle(1);

    // Compounding mispredicts on one entry: 01 -> 10 -> 11 -> 00
    applyStimulus(0, 0, 1, 3, 1, 0);
    applyStimulus(0, 0, 1, 3, 1, 0);
    idle(1);
    lookup_range(3, 3);
    applyStimulus(0, 0, 1, 3, 1, 0);
    applyStimulus(0, 0, 1, 3, 1, 0);
    idle(1);
    lookup_range(3, 3);

    // Lookups starve the port while the FIFO fills, then it drains in order.
    for (int k = 0; k < 5; k++) applyStimulus(1, 5, 1, 40 + (k % 3), k % 2, 0);
    idle(5);
    lookup_range(40, 42);

    // Every state x mispred combination on its own entry.
    for (int s = 0; s < 4; s++)
      for (int mp = 0; mp < 2; mp++) begin
        n = (s == 1) ? 0 : (s == 2) ? 1 : (s == 3) ? 2 : 3;
        repeat (n) applyStimulus(0, 0, 1, 20 + s * 2 + mp, 1, 0);
        applyStimulus(0, 0, 1, 20 + s * 2 + mp, mp, 0);
      end
    idle(2);
    lookup_range(20, 27);

    // Flush with a partly full queue and a second request mid-sweep.
    for (int i = 30; i < 34; i++) applyStimulus(0, 0, 1, i, 1, 0);
    idle(2);
    applyStimulus(1, 7, 1, 50, 1, 0);
    applyStimulus(1, 7, 1, 51, 1, 0);
    applyStimulus(0, 0, 1, 52, 1, 1);
    for (int k = 0; k < 70; k++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, ENTRIES - 1),
                    1, $urandom_range(0, ENTRIES - 1), 1, k == 10);
    lookup_range(0, ENTRIES - 1);

    // Reset mid-sweep, then mid-drain with queued updates.
    for (int i = 8; i < 12; i++) applyStimulus(0, 0, 1, i, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(20);
    async_reset();
    lookup_range(0, ENTRIES - 1);
    for (int k = 0; k < 3; k++) applyStimulus(1, k, 1, 60 + k, 1, 0);
    async_reset();
    lookup_range(58, 63);

    for (int k = 0; k < 600; k++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, ENTRIES - 1),
                    $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 149) == 0);
    idle(70);
    lookup_range(0, 15);
    idle(1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
